// File: rtl/lcd_reader_pkg.sv
// Shared definitions for the HD44780 4-bit bus read side.
// Contents: FSM state encoding, RS select values, busy-flag bit index and
// the ns-to-cycle conversion used to size every LCD timing count.
package lcd_reader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_SETUP,
        S_E1H,
        S_E1L,
        S_E2H,
        S_E2L,
        S_DONE
    } state_t;

    localparam logic LCD_RS_STATUS = 1'b0;
    localparam logic LCD_RS_DATA   = 1'b1;

    // Busy flag position in the assembled byte and within the high nibble.
    localparam int unsigned BF_BIT = 7;
    localparam int unsigned BF_NIB = BF_BIT - 4;

    // ceil(ns * MHz / 1000), never less than one cycle.
    function automatic int unsigned ns2cyc(input int unsigned ns, input int unsigned freq_mhz);
        int unsigned c;
        c = (ns * freq_mhz + 999) / 1000;
        return (c == 0) ? 1 : c;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_reader_timer.sv
// lcd_timer: loadable down-counter for LCD phase timing.
// Ports: i_clk, i_rst_n (async active-low), i_load/i_load_val (reload),
//        o_done (count has reached zero).
// Loading N-1 on state entry keeps the owning state active for N cycles.
module lcd_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// lcd_reader: read-side controller for the 4-bit HD44780 LCD bus.
// Performs one RW=1 transaction per request (status when req_rs=0, data when
// req_rs=1) after winning the shared pins through bus_req/bus_gnt, and returns
// {high nibble, low nibble} on rsp_data with a one-cycle rsp_valid.
// Ports: clk, rst (async active-low); req_valid/req_rs/req_ready request side;
//        rsp_valid/rsp_data/rsp_timeout response side; bus_req/bus_gnt pin
//        arbitration; lcd_e/lcd_rs/lcd_rw/lcd_dat_i LCD pins.
// Optional feature macro: LCD_READER_POLL_EN -- status reads with BF=1 are
// repeated without releasing the bus until BF=0 or POLL_MAX reads are done.
module lcd_reader
    import lcd_reader_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50,
    parameter int unsigned T_SETUP_NS = 60,
    parameter int unsigned T_EHIGH_NS = 480,
    parameter int unsigned T_ELOW_NS  = 520,
    parameter int unsigned POLL_MAX   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_rs,
    output logic       req_ready,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    input  logic [3:0] lcd_dat_i
);

    localparam int unsigned N_SETUP = ns2cyc(T_SETUP_NS, CLK_FREQ);
    localparam int unsigned N_EHIGH = ns2cyc(T_EHIGH_NS, CLK_FREQ);
    localparam int unsigned N_ELOW  = ns2cyc(T_ELOW_NS, CLK_FREQ);
    localparam int unsigned N_MAX   = max3(N_SETUP, N_EHIGH, N_ELOW);
    localparam int unsigned CNT_W   = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    if (POLL_MAX == 0) begin : g_bad_poll_max
        $error("lcd_reader: POLL_MAX must be at least 1");
    end

    state_t           r_state, w_state_nxt;
    logic             w_tmr_load, w_tmr_done;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_repoll;
    logic             w_own_nxt, w_busreq_nxt;
    logic             r_rs_lat;
    logic [3:0]       r_dat_sync, r_hi, r_lo;
    logic             r_req_ready, r_rsp_valid, r_bus_req;
    logic             r_lcd_e, r_lcd_rs, r_lcd_rw;
    logic [7:0]       r_rsp_data;

    lcd_timer #(.WIDTH(CNT_W)) u_timer (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (req_valid)  w_state_nxt = S_ARB;
            S_ARB:   if (bus_gnt)    w_state_nxt = S_SETUP;
            S_SETUP: if (w_tmr_done) w_state_nxt = S_E1H;
            S_E1H:   if (w_tmr_done) w_state_nxt = S_E1L;
            S_E1L:   if (w_tmr_done) w_state_nxt = S_E2H;
            S_E2H:   if (w_tmr_done) w_state_nxt = S_E2L;
            S_E2L:   if (w_tmr_done) w_state_nxt = w_repoll ? S_SETUP : S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Any state change (including the E2L -> SETUP re-poll) reloads the timer.
        w_tmr_load = (w_state_nxt != r_state);
        w_tmr_val  = '0;
        unique case (w_state_nxt)
            S_SETUP:     w_tmr_val = CNT_W'(N_SETUP - 1);
            S_E1H, S_E2H: w_tmr_val = CNT_W'(N_EHIGH - 1);
            S_E1L, S_E2L: w_tmr_val = CNT_W'(N_ELOW - 1);
            default:     w_tmr_val = '0;
        endcase

        // Pin outputs are registered from the next state so they never glitch.
        w_own_nxt    = w_state_nxt inside {S_SETUP, S_E1H, S_E1L, S_E2H, S_E2L};
        w_busreq_nxt = w_own_nxt || (w_state_nxt == S_ARB);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rs_lat    <= LCD_RS_STATUS;
            r_dat_sync  <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_bus_req   <= 1'b0;
            r_lcd_e     <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_rw    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dat_sync <= lcd_dat_i;
            if (r_state == S_IDLE && req_valid) r_rs_lat <= req_rs;
            if (r_state == S_E1H && w_tmr_done) r_hi <= r_dat_sync;
            if (r_state == S_E2H && w_tmr_done) r_lo <= r_dat_sync;
            r_req_ready <= (w_state_nxt == S_IDLE);
            r_rsp_valid <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) r_rsp_data <= {r_hi, r_lo};
            r_bus_req <= w_busreq_nxt;
            r_lcd_e   <= (w_state_nxt == S_E1H) || (w_state_nxt == S_E2H);
            r_lcd_rs  <= w_own_nxt && (r_rs_lat == LCD_RS_DATA);
            r_lcd_rw  <= w_own_nxt;
        end
    end

`ifdef LCD_READER_POLL_EN
    localparam int unsigned AW = (POLL_MAX > 1) ? $clog2(POLL_MAX) : 1;

    // r_attempt counts reads already repeated; the read in flight is r_attempt+1.
    logic [AW-1:0] r_attempt;
    logic          r_rsp_timeout;

    assign w_repoll = (r_rs_lat == LCD_RS_STATUS) && r_hi[BF_NIB] &&
                      (r_attempt < AW'(POLL_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_attempt     <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (r_state == S_IDLE && req_valid) begin
                r_attempt <= '0;
            end else if (r_state == S_E2L && w_tmr_done && w_repoll) begin
                r_attempt <= r_attempt + 1'b1;
            end
            // Reaching DONE with BF still set on a status read means the limit ran out.
            if (w_state_nxt == S_DONE) begin
                r_rsp_timeout <= (r_rs_lat == LCD_RS_STATUS) && r_hi[BF_NIB];
            end
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_repoll    = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign bus_req   = r_bus_req;
    assign lcd_e     = r_lcd_e;
    assign lcd_rs    = r_lcd_rs;
    assign lcd_rw    = r_lcd_rw;

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader. A background process plays the bus
// arbiter and the LCD (drives a queued nibble on each E rise, measures E
// widths) and scores every rsp_valid against a queue of expected responses.
// Build with LCD_READER_POLL_EN defined to also exercise busy polling.
module tb_lcd_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_rs = 1'b0;
    logic       bus_gnt = 1'b0;
    logic [3:0] lcd_dat_i = 4'h0;
    logic       req_ready, rsp_valid, rsp_timeout, bus_req, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] rsp_data;

    typedef struct {
        logic [7:0] d;
        logic       to;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] nib_q[$];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   gnt_cyc = 0;
    int   gnt_delay = 0;
    int   wait_cnt = 0;
    int   e_rises = 0;
    int   hi_cnt = 0;
    int   lo_cnt = 0;
    logic prev_e = 1'b0;
    logic cur_rs = 1'b0;

`ifdef LCD_READER_POLL_EN
    lcd_reader #(.POLL_MAX(4)) dut (
`else
    lcd_reader dut (
`endif
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_rs      (req_rs),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_timeout (rsp_timeout),
        .bus_req     (bus_req),
        .bus_gnt     (bus_gnt),
        .lcd_e       (lcd_e),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_dat_i   (lcd_dat_i)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_read(input logic [3:0] hi, input logic [3:0] lo);
        nib_q.push_back(hi);
        nib_q.push_back(lo);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic to, input int lat);
        exp_t e;
        e.d = d; e.to = to; e.lat = lat;
        exp_q.push_back(e);
    endtask

    // Issue one request from an IDLE sample point; bounded wait for req_ready.
    task automatic send(input logic rs);
        int n;
        n = 0;
        while (!req_ready && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_req", req_ready, 1'b1);
        cur_rs = rs;
        e_rises = 0;
        req_valid = 1'b1;
        req_rs = rs;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("accept_bus_req", bus_req, 1'b1);
        check("accept_not_ready", req_ready, 1'b0);
    endtask

    task automatic wait_drain(input int reads);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_pending", exp_q.size(), 0);
        check("e_rises", e_rises, 2 * reads);
    endtask

    // Arbiter, LCD model and response scoreboard, sampled 1 time unit after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                bus_gnt  = 1'b0;
                wait_cnt = 0;
                prev_e   = 1'b0;
                hi_cnt   = 0;
                lo_cnt   = 0;
            end else begin
                if (bus_req && !bus_gnt) begin
                    check("arb_e_low", lcd_e, 1'b0);
                    check("arb_rw_idle", lcd_rw, 1'b0);
                    check("arb_rs_idle", lcd_rs, 1'b0);
                    if (wait_cnt >= gnt_delay) begin
                        bus_gnt = 1'b1;
                        gnt_cyc = cyc;
                    end else begin
                        wait_cnt++;
                    end
                end else if (!bus_req) begin
                    bus_gnt  = 1'b0;
                    wait_cnt = 0;
                end
                if (lcd_rw) check("gnt_held", bus_gnt, 1'b1);

                if (lcd_e) begin
                    if (!prev_e) begin
                        if (e_rises % 2 == 1) check("e_low_width", lo_cnt, 26);
                        check("rs_at_e", lcd_rs, cur_rs);
                        check("rw_at_e", lcd_rw, 1'b1);
                        if (nib_q.size() > 0) lcd_dat_i = nib_q.pop_front();
                        else lcd_dat_i = 4'h0;
                        e_rises++;
                        hi_cnt = 0;
                    end
                    hi_cnt++;
                end else begin
                    if (prev_e) begin
                        check("e_high_width", hi_cnt, 24);
                        lo_cnt = 0;
                    end
                    lo_cnt++;
                end
                prev_e = lcd_e;

                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", rsp_valid, 1'b0);
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_data", rsp_data, e.d);
                        check("rsp_timeout", rsp_timeout, e.to);
                        check("gnt_to_rsp", cyc - gnt_cyc, e.lat);
                        check("done_bus_rel", bus_req, 1'b0);
                        check("done_rw_low", lcd_rw, 1'b0);
                    end
                end
            end
        end
    end

    initial begin
        int ready_cnt;
        int n_rsp;
        int n;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_rsp_timeout", rsp_timeout, 1'b0);
        check("rst_bus_req", bus_req, 1'b0);
        check("rst_lcd_e", lcd_e, 1'b0);
        check("rst_lcd_rs", lcd_rs, 1'b0);
        check("rst_lcd_rw", lcd_rw, 1'b0);
        #4 rst = 1'b1;
        @(posedge clk); #1;

        // Status read, immediate grant, 8/3 -> 0x83
        gnt_delay = 0;
`ifdef LCD_READER_POLL_EN
        repeat (4) push_read(4'h8, 4'h3);
        push_exp(8'h83, 1'b1, 413);
        send(1'b0);
        wait_drain(4);
`else
        push_read(4'h8, 4'h3);
        push_exp(8'h83, 1'b0, 104);
        send(1'b0);
        wait_drain(1);
`endif

        // Data read with grant delayed 50 cycles
        gnt_delay = 50;
        push_read(4'h4, 4'h1);
        push_exp(8'h41, 1'b0, 104);
        send(1'b1);
        wait_drain(1);

        // req_valid held high: second accept only after DONE
        gnt_delay = 0;
        push_read(4'h5, 4'hA);
        push_read(4'hC, 4'h7);
        push_exp(8'h5A, 1'b0, 104);
        push_exp(8'hC7, 1'b0, 104);
        cur_rs = 1'b1;
        e_rises = 0;
        req_rs = 1'b1;
        req_valid = 1'b1;
        ready_cnt = 0;
        n_rsp = 0;
        n = 0;
        while (n_rsp < 2 && n < 600) begin
            @(posedge clk); #1;
            n++;
            if (req_ready) ready_cnt++;
            if (rsp_valid) n_rsp++;
        end
        req_valid = 1'b0;
        check("held_rsp_count", n_rsp, 2);
        check("held_ready_cycles", ready_cnt, 1);
        wait_drain(2);

        // Reset pulse during E1H aborts without a response
        gnt_delay = 0;
        push_read(4'h9, 4'h9);
        send(1'b1);
        n = 0;
        while (!lcd_e && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_test_e_rise", lcd_e, 1'b1);
        repeat (5) @(posedge clk);
        #4 rst = 1'b0;
        #1;
        check("abort_lcd_e", lcd_e, 1'b0);
        check("abort_bus_req", bus_req, 1'b0);
        check("abort_lcd_rw", lcd_rw, 1'b0);
        check("abort_req_ready", req_ready, 1'b1);
        nib_q.delete();
        @(posedge clk);
        #5 rst = 1'b1;
        n_rsp = 0;
        repeat (150) begin
            @(posedge clk); #1;
            if (rsp_valid) n_rsp++;
        end
        check("abort_no_rsp", n_rsp, 0);

        // Request after reset, grant delayed 3 cycles, BF=0 status
        gnt_delay = 3;
        push_read(4'h2, 4'h7);
        push_exp(8'h27, 1'b0, 104);
        send(1'b0);
        wait_drain(1);

`ifdef LCD_READER_POLL_EN
        // Busy for three reads, then ready
        gnt_delay = 0;
        push_read(4'h8, 4'h1);
        push_read(4'h9, 4'h2);
        push_read(4'hA, 4'h3);
        push_read(4'h1, 4'h5);
        push_exp(8'h15, 1'b0, 413);
        send(1'b0);
        wait_drain(4);

        // Busy on every read: limit of 4 reads, timeout flagged
        push_read(4'h8, 4'h0);
        push_read(4'hC, 4'h1);
        push_read(4'hF, 4'h2);
        push_read(4'hB, 4'h4);
        push_exp(8'hB4, 1'b1, 413);
        send(1'b0);
        wait_drain(4);

        // Data read with BF-looking byte is never repeated
        push_read(4'h8, 4'h8);
        push_exp(8'h88, 1'b0, 104);
        send(1'b1);
        wait_drain(1);
`endif

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
